// File: rtl/megamapper_pkg.sv
// Shared definitions for the trap sequencer: FSM state encoding and the
// cause code reserved for the intercepted system IRQ.
package megamapper_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_e;

  // The IRQ cause takes the first code above the last source index.
  function automatic int irq_cause_code(input int nsrc);
    return nsrc;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Cause selector: lowest requesting source index, or the IRQ code when no
// source is requesting.
module trap_prio_enc
  import megamapper_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int CW   = $clog2(NSRC + 1)
) (
  input  logic [NSRC-1:0] i_req,
  output logic [CW-1:0]   o_code,
  output logic            o_hit
);

  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    o_code = CW'(irq_cause_code(NSRC));
    o_hit  = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      o_code = i_req[i] ? CW'(i) : o_code;
      o_hit  = o_hit | i_req[i];
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: collects per-source violations and an intercepted IRQ,
// raises NMI, and steps a RUN/TRAP machine on qualified M1 fetch edges.
module trap_sequencer
  import megamapper_pkg::*;
#(
  parameter  int NSRC        = 4,
  parameter  int NMI_TIMEOUT = 255,
  localparam int CW          = $clog2(NSRC + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m1_n,
  input  logic            rd_n,
  input  logic            irq_sys_n,
  input  logic [NSRC-1:0] src_evt,
  input  logic [NSRC-1:0] src_mask,
  input  logic            irq_intercept,
  input  logic            new_isr,
  input  logic            last_isr_untrap,
  input  logic            virtual_enabled,
  input  logic            clr_status,
  output logic            nmi_n,
  output logic            trap_state,
  output logic            capture_latch,
  output logic            irq_sync,
  output logic [NSRC-1:0] pending,
  output logic [CW-1:0]   cause,
  output logic            cause_valid,
  output logic            drop_flag,
  output logic            nmi_timeout
);

  localparam int            TW      = $clog2(NMI_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(NMI_TIMEOUT);
  localparam logic [TW-1:0] T_PRE   = TW'(NMI_TIMEOUT - 1);

  trap_state_e     r_state;
  logic            r_m1_prev;
  logic [NSRC-1:0] r_src_prev;
  logic            r_capture;
  logic            r_irq_sync;
  logic [NSRC-1:0] r_pending;
  logic [CW-1:0]   r_cause;
  logic            r_cause_valid;
  logic            r_drop;
  logic            r_nmi_timeout;
  logic [TW-1:0]   r_cnt;

  logic            w_m1_fall;
  logic            w_m1_rise;
  logic            w_qfall;
  logic [NSRC-1:0] w_src_rise;
  logic [NSRC-1:0] w_enabled;
  logic            w_trap_pending;
  logic            w_run;
  logic            w_enter_cap;
  logic            w_enter_plain;
  logic            w_exit;
  logic [CW-1:0]   w_code;
  logic            w_hit;
  logic [NSRC-1:0] w_clr_mask;
  logic [NSRC-1:0] w_accept;
  logic            w_drop;
  logic            w_nmi_low;

  assign w_m1_fall      = r_m1_prev & ~m1_n;
  assign w_m1_rise      = ~r_m1_prev & m1_n;
  assign w_qfall        = w_m1_fall & rd_n;
  assign w_src_rise     = src_evt & ~r_src_prev;
  assign w_enabled      = r_pending & src_mask;
  assign w_trap_pending = (|w_enabled) | (~r_irq_sync & irq_intercept);
  assign w_run          = (r_state == ST_RUN);

  // Capture wins over a plain (non-virtual) entry on the same fetch.
  assign w_enter_cap    = w_run & w_qfall & w_trap_pending & new_isr;
  assign w_enter_plain  = w_run & w_qfall & ~(w_trap_pending & new_isr) & ~virtual_enabled;
  assign w_exit         = ~w_run & w_qfall & last_isr_untrap & virtual_enabled;

  assign w_clr_mask = (w_enter_cap & w_hit) ? (NSRC'(1'b1) << w_code) : {NSRC{1'b0}};
  assign w_accept   = w_run ? w_src_rise : {NSRC{1'b0}};
  assign w_drop     = ~w_run & (|w_src_rise);

  assign nmi_n     = ~(~rst & w_run & w_trap_pending & m1_n);
  assign w_nmi_low = ~nmi_n;

  trap_prio_enc #(
    .NSRC (NSRC),
    .CW   (CW)
  ) u_prio (
    .i_req  (w_enabled),
    .o_code (w_code),
    .o_hit  (w_hit)
  );

  // Sequencer state, pending set, status flags and NMI watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_TRAP;
      r_m1_prev     <= 1'b1;
      r_src_prev    <= {NSRC{1'b0}};
      r_capture     <= 1'b0;
      r_irq_sync    <= 1'b1;
      r_pending     <= {NSRC{1'b0}};
      r_cause       <= {CW{1'b0}};
      r_cause_valid <= 1'b0;
      r_drop        <= 1'b0;
      r_nmi_timeout <= 1'b0;
      r_cnt         <= {TW{1'b0}};
    end else begin
      r_m1_prev  <= m1_n;
      r_src_prev <= src_evt;
      if (w_m1_rise) r_irq_sync <= irq_sys_n;
      r_pending <= (r_pending & ~w_clr_mask) | w_accept;

      case (r_state)
        ST_RUN:  if (w_enter_cap || w_enter_plain) r_state <= ST_TRAP;
        ST_TRAP: if (w_exit) r_state <= ST_RUN;
        default: r_state <= ST_TRAP;
      endcase

      if (w_enter_cap)  r_capture <= 1'b1;
      else if (w_qfall) r_capture <= 1'b0;

      if (w_enter_cap) r_cause <= w_code;

      if (w_enter_cap)     r_cause_valid <= 1'b1;
      else if (clr_status) r_cause_valid <= 1'b0;

      if (w_drop)          r_drop <= 1'b1;
      else if (clr_status) r_drop <= 1'b0;

      if (!w_nmi_low)            r_cnt <= {TW{1'b0}};
      else if (r_cnt != T_LIMIT) r_cnt <= r_cnt + TW'(1'b1);

      if (w_nmi_low && (r_cnt >= T_PRE)) r_nmi_timeout <= 1'b1;
      else if (clr_status)               r_nmi_timeout <= 1'b0;
    end
  end

  assign trap_state    = (r_state == ST_TRAP);
  assign capture_latch = r_capture;
  assign irq_sync      = r_irq_sync;
  assign pending       = r_pending;
  assign cause         = r_cause;
  assign cause_valid   = r_cause_valid;
  assign drop_flag     = r_drop;
  assign nmi_timeout   = r_nmi_timeout;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed scenarios then random traffic,
// checked cycle by cycle against a behavioural model.
module tb_trap_sequencer;

  localparam int NSRC        = 4;
  localparam int NMI_TIMEOUT = 8;
  localparam int CW          = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, m1_n, rd_n, irq_sys_n;
  logic [NSRC-1:0] src_evt, src_mask;
  logic            irq_intercept, new_isr, last_isr_untrap, virtual_enabled, clr_status;
  logic            nmi_n, trap_state, capture_latch, irq_sync;
  logic [NSRC-1:0] pending;
  logic [CW-1:0]   cause;
  logic            cause_valid, drop_flag, nmi_timeout;

  trap_sequencer #(.NSRC(NSRC), .NMI_TIMEOUT(NMI_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .m1_n(m1_n), .rd_n(rd_n), .irq_sys_n(irq_sys_n),
    .src_evt(src_evt), .src_mask(src_mask), .irq_intercept(irq_intercept),
    .new_isr(new_isr), .last_isr_untrap(last_isr_untrap),
    .virtual_enabled(virtual_enabled), .clr_status(clr_status),
    .nmi_n(nmi_n), .trap_state(trap_state), .capture_latch(capture_latch),
    .irq_sync(irq_sync), .pending(pending), .cause(cause),
    .cause_valid(cause_valid), .drop_flag(drop_flag), .nmi_timeout(nmi_timeout)
  );

  typedef struct {
    logic nmi_n, trap_state, capture_latch, irq_sync;
    logic [NSRC-1:0] pending;
    logic [CW-1:0] cause;
    logic cause_valid, drop_flag, nmi_timeout;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passed = 0;

  // Behavioural model state
  bit            m_trap, m_cap, m_isync, m_cv, m_drop, m_to, m_pm1;
  bit [NSRC-1:0] m_pend, m_psrc;
  int            m_cause, m_low;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_trap = 1'b1; m_cap = 1'b0; m_isync = 1'b1; m_cv = 1'b0; m_drop = 1'b0;
    m_to = 1'b0; m_pm1 = 1'b1; m_pend = '0; m_psrc = '0; m_cause = 0; m_low = 0;
  endfunction

  function automatic int lowest_enabled();
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && src_mask[i]) return i;
    return -1;
  endfunction

  function automatic bit model_trap_pending();
    return (lowest_enabled() >= 0) || (!m_isync && irq_intercept);
  endfunction

  function automatic bit model_nmi_low();
    return !rst && !m_trap && model_trap_pending() && m1_n;
  endfunction

  function automatic void model_step();
    bit fall, rise, tp, low, enter_cap, enter_plain, leave;
    int idx;
    bit [NSRC-1:0] n_pend;
    if (rst) begin
      model_reset();
      return;
    end
    low  = model_nmi_low();
    fall = m_pm1 && !m1_n && rd_n;
    rise = !m_pm1 && m1_n;
    idx  = lowest_enabled();
    tp   = model_trap_pending();
    enter_cap   = !m_trap && fall && tp && new_isr;
    enter_plain = !m_trap && fall && !enter_cap && !virtual_enabled;
    leave       = m_trap && fall && last_isr_untrap && virtual_enabled;
    if (clr_status) begin m_cv = 1'b0; m_drop = 1'b0; m_to = 1'b0; end
    n_pend = m_pend;
    if (enter_cap && idx >= 0) n_pend[idx] = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (src_evt[i] && !m_psrc[i]) begin
        if (m_trap) m_drop = 1'b1;
        else n_pend[i] = 1'b1;
      end
    if (enter_cap) begin
      m_cap = 1'b1; m_cv = 1'b1;
      m_cause = (idx >= 0) ? idx : NSRC;
    end else if (fall) m_cap = 1'b0;
    if (enter_cap || enter_plain) m_trap = 1'b1;
    else if (leave) m_trap = 1'b0;
    if (rise) m_isync = irq_sys_n;
    if (low) begin
      m_low = (m_low + 1 > NMI_TIMEOUT) ? NMI_TIMEOUT : m_low + 1;
      if (m_low >= NMI_TIMEOUT) m_to = 1'b1;
    end else m_low = 0;
    m_pend = n_pend;
    m_pm1  = m1_n;
    m_psrc = src_evt;
  endfunction

  // Push what the DUT shows during this cycle, advance the model, then clock.
  task automatic tick();
    exp_t e;
    e.nmi_n = !model_nmi_low();
    e.trap_state = m_trap; e.capture_latch = m_cap; e.irq_sync = m_isync;
    e.pending = m_pend; e.cause = CW'(m_cause); e.cause_valid = m_cv;
    e.drop_flag = m_drop; e.nmi_timeout = m_to;
    exp_q.push_back(e);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the expectation for the current cycle and compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mon_nmi_n", 8'(nmi_n), 8'(e.nmi_n));
      chk("mon_trap_state", 8'(trap_state), 8'(e.trap_state));
      chk("mon_capture_latch", 8'(capture_latch), 8'(e.capture_latch));
      chk("mon_irq_sync", 8'(irq_sync), 8'(e.irq_sync));
      chk("mon_pending", 8'(pending), 8'(e.pending));
      chk("mon_cause", 8'(cause), 8'(e.cause));
      chk("mon_cause_valid", 8'(cause_valid), 8'(e.cause_valid));
      chk("mon_drop_flag", 8'(drop_flag), 8'(e.drop_flag));
      chk("mon_nmi_timeout", 8'(nmi_timeout), 8'(e.nmi_timeout));
    end
  end

  task automatic qfall_seq();
    m1_n = 1'b1; tick();
    m1_n = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; m1_n = 1'b1; rd_n = 1'b1; irq_sys_n = 1'b1;
    src_evt = 4'b0000; src_mask = 4'b1111; irq_intercept = 1'b0;
    new_isr = 1'b0; last_isr_untrap = 1'b0; virtual_enabled = 1'b1; clr_status = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    tick(); tick();
    chk("reset_trap_state", 8'(trap_state), 8'd1);
    chk("reset_pending", 8'(pending), 8'd0);
    chk("reset_irq_sync", 8'(irq_sync), 8'd1);
    chk("reset_nmi_n", 8'(nmi_n), 8'd1);
    rst = 1'b0;

    // Non-virtual fetch out of reset stays trapped without a cause.
    virtual_enabled = 1'b0;
    qfall_seq();
    chk("novirt_trap_state", 8'(trap_state), 8'd1);
    chk("novirt_nmi_n", 8'(nmi_n), 8'd1);
    chk("novirt_cause_valid", 8'(cause_valid), 8'd0);
    virtual_enabled = 1'b1;

    last_isr_untrap = 1'b1;
    qfall_seq();
    chk("untrap_run", 8'(trap_state), 8'd0);
    last_isr_untrap = 1'b0;

    // Two sources pend; capture picks the lowest and clears only it.
    m1_n = 1'b1; src_evt = 4'b0100; tick();
    src_evt = 4'b0110; tick();
    chk("two_pending", 8'(pending), 8'd6);
    new_isr = 1'b1;
    m1_n = 1'b0; tick();
    chk("cap_cause", 8'(cause), 8'd1);
    chk("cap_pending", 8'(pending), 8'd4);
    chk("cap_latch_set", 8'(capture_latch), 8'd1);
    chk("cap_trap_state", 8'(trap_state), 8'd1);
    new_isr = 1'b0;
    m1_n = 1'b1; tick(); tick();
    chk("cap_latch_held", 8'(capture_latch), 8'd1);
    m1_n = 1'b0; tick();
    chk("cap_latch_clear", 8'(capture_latch), 8'd0);

    // Edge while trapped is dropped; clr_status clears the flag.
    m1_n = 1'b1; src_evt = 4'b0111; tick();
    chk("drop_pending", 8'(pending), 8'd4);
    chk("drop_flag_set", 8'(drop_flag), 8'd1);
    clr_status = 1'b1; tick();
    chk("drop_flag_clr", 8'(drop_flag), 8'd0);
    clr_status = 1'b0;

    // Untrap fetch and a source edge on the same clock see TRAP.
    last_isr_untrap = 1'b1;
    m1_n = 1'b0; src_evt = 4'b1111; tick();
    chk("exit_run", 8'(trap_state), 8'd0);
    chk("exit_drop", 8'(drop_flag), 8'd1);
    chk("exit_pending", 8'(pending), 8'd4);
    last_isr_untrap = 1'b0;

    // Retained pending re-raises NMI; watchdog fires after NMI_TIMEOUT cycles.
    m1_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("wd_nmi_n", 8'(nmi_n), 8'd0);
      chk("wd_timeout", 8'(nmi_timeout), (k >= NMI_TIMEOUT) ? 8'd1 : 8'd0);
    end

    // Masked pending is kept; intercepted IRQ syncs only at M1 rise.
    src_mask = 4'b1011; irq_intercept = 1'b1; irq_sys_n = 1'b0; tick();
    chk("irq_no_rise", 8'(irq_sync), 8'd1);
    chk("masked_kept", 8'(pending), 8'd4);
    m1_n = 1'b0; tick();
    chk("irq_at_fall", 8'(irq_sync), 8'd1);
    chk("masked_no_entry", 8'(trap_state), 8'd0);
    m1_n = 1'b1; tick();
    chk("irq_at_rise", 8'(irq_sync), 8'd0);
    new_isr = 1'b1;
    m1_n = 1'b0; tick();
    chk("irq_cause", 8'(cause), 8'd4);
    chk("irq_trap_state", 8'(trap_state), 8'd1);
    chk("irq_pending", 8'(pending), 8'd4);
    irq_intercept = 1'b0; irq_sys_n = 1'b1; src_mask = 4'b1111;

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) m1_n = ~m1_n;
      rd_n = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) irq_sys_n = ~irq_sys_n;
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 7) == 0) src_evt[i] = ~src_evt[i];
      if ($urandom_range(0, 49) == 0) src_mask = NSRC'($urandom);
      irq_intercept   = 1'($urandom_range(0, 1));
      new_isr         = ($urandom_range(0, 3) != 0);
      last_isr_untrap = 1'($urandom_range(0, 1));
      virtual_enabled = ($urandom_range(0, 6) != 0);
      clr_status      = ($urandom_range(0, 19) == 0);
      tick();
    end

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
